key_search_ctrl_mc: RTL

- Multi-core successor to the single-core key sweep controller for the RC4 brute-force decoder.
- Splits the secret-key space [0, KEY_LIMIT) across NUM_CORES parallel decrypt cores, one key per core per round.
- Collects per-core pass/fail and latches the first winning key (lowest index on ties).
- Drives the status LEDs and reports an exhausted-search condition.

---
 rtl/key_search_ctrl_mc.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/key_search_ctrl_mc.sv
// key_search_ctrl_mc: multi-core key sweep controller for the RC4 brute-force
// decoder. Hands out one key per core per round, gathers pass/fail verdicts,
// latches the lowest-index winning key or reports that the range is exhausted.
// Optional build macro KEY_SEARCH_PROGRESS_EN: shows the upper bits of the
// current key base on LEDR[LED_W-1:3]; when undefined those LEDs are tied to 0.
module key_search_ctrl_mc #(
  parameter int              KEY_W     = 24,
  parameter int              NUM_CORES = 4,
  parameter longint unsigned KEY_LIMIT = 64'h0000_0000_0040_0000,
  parameter int              LED_W     = 10
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [NUM_CORES-1:0]       core_done,
  input  logic [NUM_CORES-1:0]       core_success,
  output logic [NUM_CORES-1:0]       core_start,
  output logic [NUM_CORES*KEY_W-1:0] core_key,
  output logic                       found,
  output logic [KEY_W-1:0]           found_key,
  output logic                       exhausted,
  output logic                       busy,
  output logic [LED_W-1:0]           LEDR
);

  localparam int IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam logic [KEY_W:0] LIMIT_EXT = (KEY_W+1)'(KEY_LIMIT);
  localparam logic [KEY_W:0] STRIDE    = (KEY_W+1)'(NUM_CORES);

  typedef enum logic [2:0] {
    IDLE,
    DISPATCH,
    RUN,
    FOUND,
    EXHAUSTED
  } state_t;

  state_t                     state_q, state_d;
  logic [KEY_W:0]             next_key_q, next_key_d;
  logic [NUM_CORES-1:0]       active_q, active_d;
  logic [NUM_CORES-1:0]       done_q, done_d;
  logic [NUM_CORES-1:0]       succ_q, succ_d;
  logic [NUM_CORES-1:0]       core_start_q, core_start_d;
  logic [NUM_CORES*KEY_W-1:0] core_key_q, core_key_d;
  logic                       found_q, found_d;
  logic [KEY_W-1:0]           found_key_q, found_key_d;
  logic                       exhausted_q, exhausted_d;

  logic [NUM_CORES-1:0]       done_new;
  logic [NUM_CORES-1:0]       succ_new;
  logic [IDX_W-1:0]           win_idx;
  logic [KEY_W:0]             win_key;
  logic [KEY_W:0]             slot_key;

  // State and datapath registers; everything clears asynchronously on reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      next_key_q   <= '0;
      active_q     <= '0;
      done_q       <= '0;
      succ_q       <= '0;
      core_start_q <= '0;
      core_key_q   <= '0;
      found_q      <= 1'b0;
      found_key_q  <= '0;
      exhausted_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      next_key_q   <= next_key_d;
      active_q     <= active_d;
      done_q       <= done_d;
      succ_q       <= succ_d;
      core_start_q <= core_start_d;
      core_key_q   <= core_key_d;
      found_q      <= found_d;
      found_key_q  <= found_key_d;
      exhausted_q  <= exhausted_d;
    end
  end

  // Next-state logic: sweep rounds, verdict collection and the core key load
  // that happens on every transition into DISPATCH.
  always_comb begin
    state_d      = state_q;
    next_key_d   = next_key_q;
    active_d     = active_q;
    done_d       = done_q;
    succ_d       = succ_q;
    core_start_d = '0;
    core_key_d   = core_key_q;
    found_d      = found_q;
    found_key_d  = found_key_q;
    exhausted_d  = exhausted_q;
    slot_key     = '0;
    win_idx      = '0;

    // Results from cores that were not handed a key this round never count.
    done_new = done_q | (core_done & active_q);
    succ_new = succ_q | (core_done & core_success & active_q);

    // Scan downwards so the lowest successful core index ends up in win_idx.
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      if (succ_new[i]) begin
        win_idx = IDX_W'(i);
      end
    end
    win_key = next_key_q + (KEY_W+1)'(win_idx);

    case (state_q)
      IDLE: begin
        if (start) begin
          next_key_d = '0;
          state_d    = DISPATCH;
        end
      end

      DISPATCH: begin
        // Anything a core reports while its start pulse is out is stale.
        done_d  = '0;
        succ_d  = '0;
        state_d = RUN;
      end

      RUN: begin
        done_d = done_new;
        succ_d = succ_new;
        if (done_new == active_q) begin
          if (succ_new != '0) begin
            found_key_d = win_key[KEY_W-1:0];
            found_d     = 1'b1;
            state_d     = FOUND;
          end else begin
            next_key_d = next_key_q + STRIDE;
            if (next_key_d >= LIMIT_EXT) begin
              exhausted_d = 1'b1;
              state_d     = EXHAUSTED;
            end else begin
              state_d = DISPATCH;
            end
          end
        end
      end

      FOUND, EXHAUSTED: begin
        if (start) begin
          found_d     = 1'b0;
          exhausted_d = 1'b0;
          next_key_d  = '0;
          state_d     = DISPATCH;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Keys are registered on entry to DISPATCH so core_start and core_key
    // appear together and the keys then stay put for the whole round.
    if (state_d == DISPATCH) begin
      for (int i = 0; i < NUM_CORES; i++) begin
        slot_key    = next_key_d + (KEY_W+1)'(i);
        active_d[i] = (slot_key < LIMIT_EXT);
        core_key_d[i*KEY_W +: KEY_W] = active_d[i] ? slot_key[KEY_W-1:0] : '0;
      end
      core_start_d = active_d;
    end
  end

  assign core_start = core_start_q;
  assign core_key   = core_key_q;
  assign found      = found_q;
  assign found_key  = found_key_q;
  assign exhausted  = exhausted_q;
  assign busy       = (state_q == DISPATCH) || (state_q == RUN);

`ifdef KEY_SEARCH_PROGRESS_EN
  assign LEDR = {next_key_q[KEY_W-1 -: LED_W-3], exhausted_q, found_q, busy};
`else
  assign LEDR = {{(LED_W-3){1'b0}}, exhausted_q, found_q, busy};
`endif

endmodule
